// File: rtl/hex_display_pkg.sv
// Shared constants for 7-segment hex display blocks: segment codes, bit
// positions on the segment bus and the blank anode pattern.
package hex_display_pkg;

    localparam int SEG_A  = 7;
    localparam int SEG_B  = 6;
    localparam int SEG_C  = 5;
    localparam int SEG_D  = 4;
    localparam int SEG_E  = 3;
    localparam int SEG_F  = 2;
    localparam int SEG_G  = 1;
    localparam int SEG_DP = 0;

    localparam logic [3:0] ANODES_BLANK = 4'hF;

    // Segment codes {a,b,c,d,e,f,g} for nibble values 0..F.
    localparam logic [6:0] SEG_HEX [0:15] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

endpackage

// File: rtl/hex_display_decoder_seg7_to_hex.sv
// Combinational segment-code to nibble lookup; legal is low for any pattern
// that is not one of the sixteen hex glyphs.
module seg7_to_hex
    import hex_display_pkg::*;
(
    input  logic [6:0] seg,
    output logic       legal,
    output logic [3:0] nibble
);

    always_comb begin
        legal  = 1'b0;
        nibble = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (seg == SEG_HEX[i]) begin
                legal  = 1'b1;
                nibble = 4'(i);
            end
        end
    end

endmodule

// File: rtl/hex_display_decoder.sv
// Capture side of a multiplexed 7-segment hex display: debounces each scanned
// digit, decodes it and reassembles 16-bit words. HEX_DECODE_DP_EN adds o_dp.
module hex_display_decoder
    import hex_display_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  i_anodes,
    input  logic [7:0]  i_segments,
    output logic [3:0]  o_digit,
    output logic [1:0]  o_digit_pos,
    output logic        o_digit_valid,
    output logic [15:0] o_data,
    output logic        o_valid,
`ifdef HEX_DECODE_DP_EN
    output logic [3:0]  o_dp,
`endif
    output logic        o_err
);

`ifdef HEX_DECODE_DP_EN
    localparam int PAT_W = 12;
`else
    localparam int PAT_W = 11;
`endif
    localparam logic [CNT_W-1:0] STABLE  = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] RUN_MAX = '1;

    logic [3:0]       an_q;
    logic [7:0]       seg_q;
    logic [PAT_W-1:0] pat, prev_pat;
    logic [CNT_W-1:0] run_cnt, run_next;
    logic             new_pat, accept;
    logic [3:0]       mask, mask_new;
    logic [15:0]      shadow, shadow_new;
    logic [3:0]       dp_shadow, dp_new;
    logic             pos_ok;
    logic [1:0]       pos;
    logic             legal;
    logic [3:0]       nibble;

    seg7_to_hex u_seg7_to_hex (
        .seg    (seg_q[SEG_A:SEG_G]),
        .legal  (legal),
        .nibble (nibble)
    );

    // Without the dp feature a blinking decimal point must not restart the run.
`ifdef HEX_DECODE_DP_EN
    assign pat = {an_q, seg_q};
`else
    assign pat = {an_q, seg_q[SEG_A:SEG_G]};
`endif

    always_comb begin
        new_pat  = (pat != prev_pat);
        run_next = new_pat ? CNT_W'(1) :
                   (run_cnt == RUN_MAX) ? run_cnt : run_cnt + 1'b1;
        accept   = (run_next == STABLE) && (new_pat || run_cnt != STABLE);

        pos_ok = 1'b1;
        pos    = 2'd0;
        case (an_q)
            4'b1110: pos = 2'd0;
            4'b1101: pos = 2'd1;
            4'b1011: pos = 2'd2;
            4'b0111: pos = 2'd3;
            default: pos_ok = 1'b0;
        endcase

        shadow_new = shadow;
        shadow_new[{pos, 2'b00} +: 4] = nibble;
        dp_new      = dp_shadow;
        dp_new[pos] = seg_q[SEG_DP];
        mask_new    = mask | (4'b0001 << pos);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            an_q          <= ANODES_BLANK;
            seg_q         <= 8'h00;
            prev_pat      <= '0;
            run_cnt       <= '0;
            mask          <= 4'h0;
            shadow        <= 16'h0000;
            dp_shadow     <= 4'h0;
            o_digit       <= 4'h0;
            o_digit_pos   <= 2'd0;
            o_digit_valid <= 1'b0;
            o_data        <= 16'h0000;
            o_valid       <= 1'b0;
            o_err         <= 1'b0;
`ifdef HEX_DECODE_DP_EN
            o_dp          <= 4'h0;
`endif
        end else begin
            an_q          <= i_anodes;
            seg_q         <= i_segments;
            prev_pat      <= pat;
            run_cnt       <= run_next;
            o_digit_valid <= 1'b0;
            o_valid       <= 1'b0;
            o_err         <= 1'b0;

            if (accept && an_q != ANODES_BLANK) begin
                if (!pos_ok || !legal) begin
                    o_err <= 1'b1;
                    mask  <= 4'h0;
                end else begin
                    shadow        <= shadow_new;
                    dp_shadow     <= dp_new;
                    o_digit       <= nibble;
                    o_digit_pos   <= pos;
                    o_digit_valid <= 1'b1;
                    if (mask_new == 4'hF) begin
                        o_data  <= shadow_new;
                        o_valid <= 1'b1;
                        mask    <= 4'h0;
`ifdef HEX_DECODE_DP_EN
                        o_dp    <= dp_new;
`endif
                    end else begin
                        mask <= mask_new;
                    end
                end
            end
        end
    end

endmodule
